// File: rtl/smol_pkg.sv
// Shared types and constants for the smol load/store unit.
package smol_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic CAUSE_MISALIGN = 1'b0;
  localparam logic CAUSE_TIMEOUT  = 1'b1;

endpackage

// File: rtl/smol_lsu_if.sv
// Execute-side request, data-memory port and writeback completion bundle.
interface smol_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        done_valid;
  logic        done_we;
  logic [4:0]  done_rd;
  logic [31:0] done_data;
  logic        fault;
  logic        fault_cause;

  // LSU side: masters the memory port, serves the execute stage.
  modport master (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
    output req_ready,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output done_valid, done_we, done_rd, done_data, fault, fault_cause
  );

  modport slave (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  done_valid, done_we, done_rd, done_data, fault, fault_cause
  );
endinterface

// File: rtl/smol_lsu_align.sv
// Byte-lane steering for stores, lane extraction/extension for loads,
// and misalignment detection; purely combinational.
module smol_lsu_align
  import smol_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic        misaligned
);

  logic [31:0] lane_s;

  // Decode width code into strobes, steered data, extended load and alignment.
  always_comb begin
    lane_s     = ld_word >> {addr_lo, 3'b000};
    wstrb      = 4'b1111;
    wdata      = st_data;
    ld_data    = ld_word;
    misaligned = 1'b0;
    case (funct3)
      F3_B: begin
        wstrb   = 4'b0001 << addr_lo;
        wdata   = {4{st_data[7:0]}};
        ld_data = {{24{lane_s[7]}}, lane_s[7:0]};
      end
      F3_BU: begin
        wstrb   = 4'b0001 << addr_lo;
        wdata   = {4{st_data[7:0]}};
        ld_data = {24'h000000, lane_s[7:0]};
      end
      F3_H: begin
        wstrb      = 4'b0011 << addr_lo;
        wdata      = {2{st_data[15:0]}};
        ld_data    = {{16{lane_s[15]}}, lane_s[15:0]};
        misaligned = addr_lo[0];
      end
      F3_HU: begin
        wstrb      = 4'b0011 << addr_lo;
        wdata      = {2{st_data[15:0]}};
        ld_data    = {16'h0000, lane_s[15:0]};
        misaligned = addr_lo[0];
      end
      // F3_W and the unsupported codes all behave as a word access
      default: begin
        wstrb      = 4'b1111;
        wdata      = st_data;
        ld_data    = ld_word;
        misaligned = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/smol_lsu.sv
// Single-outstanding load/store unit between the execute ALU and data memory,
// with misalignment and bus-timeout faults reported on the completion pulse.
module smol_lsu
  import smol_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  smol_lsu_if.master bus
);

  localparam logic        TO_EN   = (TIMEOUT_CYCLES != 32'd0);
  localparam logic [31:0] TO_LAST = TIMEOUT_CYCLES - 32'd1;

  lsu_state_t  state_r, state_s;
  logic        accept_s, gnt_s, rvalid_s, timeout_s, expired_s;
  logic        is_store_r;
  logic [2:0]  funct3_r, al_f3_s;
  logic [1:0]  addr_lo_r, al_lo_s;
  logic [4:0]  rd_r;
  logic [31:0] cnt_r;
  logic [3:0]  al_wstrb_s;
  logic [31:0] al_wdata_s, al_ld_s;
  logic        al_mis_s;

  logic        req_ready_r, mem_req_r, mem_we_r;
  logic [31:0] mem_addr_r, mem_wdata_r;
  logic [3:0]  mem_wstrb_r;
  logic        done_valid_r, done_we_r, fault_r, fault_cause_r;
  logic [4:0]  done_rd_r;
  logic [31:0] done_data_r;

  // In IDLE the aligner sees the incoming request; afterwards the captured one.
  always_comb begin
    if (state_r == IDLE) begin
      al_f3_s = bus.req_funct3;
      al_lo_s = bus.req_addr[1:0];
    end else begin
      al_f3_s = funct3_r;
      al_lo_s = addr_lo_r;
    end
  end

  smol_lsu_align u_align (
    .funct3     (al_f3_s),
    .addr_lo    (al_lo_s),
    .st_data    (bus.req_wdata),
    .ld_word    (bus.mem_rdata),
    .wstrb      (al_wstrb_s),
    .wdata      (al_wdata_s),
    .ld_data    (al_ld_s),
    .misaligned (al_mis_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic; grant/rvalid take priority over an expiring watchdog.
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    gnt_s     = 1'b0;
    rvalid_s  = 1'b0;
    timeout_s = 1'b0;
    expired_s = TO_EN && (cnt_r >= TO_LAST);
    case (state_r)
      IDLE: begin
        if (bus.req_valid && req_ready_r) begin
          accept_s = 1'b1;
          state_s  = al_mis_s ? DONE : REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (bus.mem_gnt) begin
          gnt_s   = 1'b1;
          state_s = is_store_r ? DONE : WAIT_R;
        end else if (expired_s) begin
          timeout_s = 1'b1;
          state_s   = DONE;
        end else begin
          state_s = REQ;
        end
      end
      WAIT_R: begin
        if (bus.mem_rvalid) begin
          rvalid_s = 1'b1;
          state_s  = DONE;
        end else if (expired_s) begin
          timeout_s = 1'b1;
          state_s   = DONE;
        end else begin
          state_s = WAIT_R;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Request capture, memory port, watchdog and completion registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_r   <= 1'b1;
      is_store_r    <= 1'b0;
      funct3_r      <= 3'b000;
      addr_lo_r     <= 2'b00;
      rd_r          <= 5'd0;
      cnt_r         <= 32'd0;
      mem_req_r     <= 1'b0;
      mem_we_r      <= 1'b0;
      mem_addr_r    <= 32'd0;
      mem_wdata_r   <= 32'd0;
      mem_wstrb_r   <= 4'b0000;
      done_valid_r  <= 1'b0;
      done_we_r     <= 1'b0;
      done_rd_r     <= 5'd0;
      done_data_r   <= 32'd0;
      fault_r       <= 1'b0;
      fault_cause_r <= 1'b0;
    end else begin
      req_ready_r <= (state_s == IDLE);
      if (((state_r == REQ) || (state_r == WAIT_R)) &&
          ((state_s == REQ) || (state_s == WAIT_R))) begin
        cnt_r <= cnt_r + 32'd1;
      end else begin
        cnt_r <= 32'd0;
      end
      if (accept_s) begin
        is_store_r  <= bus.req_is_store;
        funct3_r    <= bus.req_funct3;
        addr_lo_r   <= bus.req_addr[1:0];
        rd_r        <= bus.req_rd;
        mem_req_r   <= !al_mis_s;
        mem_we_r    <= bus.req_is_store;
        mem_addr_r  <= {bus.req_addr[31:2], 2'b00};
        mem_wdata_r <= bus.req_is_store ? al_wdata_s : 32'd0;
        mem_wstrb_r <= bus.req_is_store ? al_wstrb_s : 4'b0000;
      end else if (gnt_s || timeout_s) begin
        mem_req_r <= 1'b0;
      end else begin
        mem_req_r <= mem_req_r;
      end
      if (state_s == DONE) begin
        done_valid_r  <= 1'b1;
        done_rd_r     <= accept_s ? bus.req_rd : rd_r;
        done_we_r     <= rvalid_s && (rd_r != 5'd0);
        done_data_r   <= rvalid_s ? al_ld_s : 32'd0;
        fault_r       <= accept_s || timeout_s;
        fault_cause_r <= timeout_s ? CAUSE_TIMEOUT : CAUSE_MISALIGN;
      end else begin
        done_valid_r  <= 1'b0;
        done_rd_r     <= 5'd0;
        done_we_r     <= 1'b0;
        done_data_r   <= 32'd0;
        fault_r       <= 1'b0;
        fault_cause_r <= 1'b0;
      end
    end
  end

  assign bus.req_ready   = req_ready_r;
  assign bus.mem_req     = mem_req_r;
  assign bus.mem_we      = mem_we_r;
  assign bus.mem_addr    = mem_addr_r;
  assign bus.mem_wdata   = mem_wdata_r;
  assign bus.mem_wstrb   = mem_wstrb_r;
  assign bus.done_valid  = done_valid_r;
  assign bus.done_we     = done_we_r;
  assign bus.done_rd     = done_rd_r;
  assign bus.done_data   = done_data_r;
  assign bus.fault       = fault_r;
  assign bus.fault_cause = fault_cause_r;

endmodule

// File: tb/tb_smol_lsu.sv
// Directed bench for smol_lsu: per-cycle comparison against a transaction-level
// model plus literal pins for the headline cases.
module tb_smol_lsu;
  import smol_pkg::*;

  localparam int TO = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cyc;
  int   acc_cyc;
  int   done_cyc;
  logic chk_en;
  logic [31:0] last_data;
  logic [31:0] last_wdata;
  logic [3:0]  last_wstrb;

  logic        exp_ready, exp_mem_req, exp_we, exp_done, exp_done_we, exp_fault, exp_cause;
  logic [31:0] exp_addr, exp_wdata, exp_data;
  logic [3:0]  exp_wstrb;
  logic [4:0]  exp_rd;

  smol_lsu_if bus ();

  smol_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    if (f3 == F3_B || f3 == F3_BU) return 1;
    if (f3 == F3_H || f3 == F3_HU) return 2;
    return 4;
  endfunction

  function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
    return (a % nbytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = nbytes(f3);
    if (n == 4) return 4'b1111;
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    int n;
    n = nbytes(f3);
    if (n == 1) return (d & 32'hFF) * 32'h01010101;
    if (n == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v;
    v = w >> ((a % 4) * 8);
    if (f3 == F3_B)  return ((v & 32'h80) != 0) ? ((v & 32'hFF) | 32'hFFFFFF00) : (v & 32'hFF);
    if (f3 == F3_BU) return v & 32'hFF;
    if (f3 == F3_H)  return ((v & 32'h8000) != 0) ? ((v & 32'hFFFF) | 32'hFFFF0000) : (v & 32'hFFFF);
    if (f3 == F3_HU) return v & 32'hFFFF;
    return w;
  endfunction

  // Per-cycle comparison of DUT outputs against the model's expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      chk("mem_req", 32'(bus.mem_req), 32'(exp_mem_req));
      if (exp_mem_req) begin
        chk("mem_addr", bus.mem_addr, exp_addr);
        chk("mem_we", 32'(bus.mem_we), 32'(exp_we));
        if (exp_we) begin
          chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(exp_wstrb));
          chk("mem_wdata", bus.mem_wdata, exp_wdata);
          last_wstrb = bus.mem_wstrb;
          last_wdata = bus.mem_wdata;
        end
      end
      chk("done_valid", 32'(bus.done_valid), 32'(exp_done));
      if (exp_done) begin
        chk("done_we", 32'(bus.done_we), 32'(exp_done_we));
        chk("done_rd", 32'(bus.done_rd), 32'(exp_rd));
        chk("done_data", bus.done_data, exp_data);
        chk("fault", 32'(bus.fault), 32'(exp_fault));
        if (exp_fault) chk("fault_cause", 32'(bus.fault_cause), 32'(exp_cause));
        last_data = bus.done_data;
        done_cyc  = cyc;
      end
      if (bus.req_valid && bus.req_ready) acc_cyc = cyc;
    end
  end

  task automatic set_idle();
    exp_ready   = 1'b1;
    exp_mem_req = 1'b0;
    exp_done    = 1'b0;
  endtask

  // Drive one access from an idle cycle through completion and back to idle.
  task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd,
                         input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
    int used;
    int j;
    logic got;
    logic timed;
    bus.req_valid    = 1'b1;
    bus.req_is_store = st;
    bus.req_funct3   = f3;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    bus.req_rd       = rd;
    set_idle();
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    exp_ready     = 1'b0;
    timed         = 1'b0;
    if (m_mis(f3, addr)) begin
      exp_fault = 1'b1;
      exp_cause = 1'b0;
    end else begin
      used        = 0;
      got         = 1'b0;
      exp_mem_req = 1'b1;
      exp_addr    = addr & 32'hFFFFFFFC;
      exp_we      = st;
      exp_wstrb   = m_strb(f3, addr);
      exp_wdata   = m_wdata(f3, wd);
      while (!got && !timed) begin
        bus.mem_gnt = (used == gnt_dly);
        @(posedge clk); #1;
        if (used == gnt_dly) got = 1'b1;
        else if (used + 1 >= TO) timed = 1'b1;
        used++;
      end
      bus.mem_gnt = 1'b0;
      exp_mem_req = 1'b0;
      if (!st && !timed) begin
        got = 1'b0;
        j   = 0;
        while (!got && !timed) begin
          bus.mem_rvalid = (j == rv_dly);
          bus.mem_rdata  = (j == rv_dly) ? rdata : 32'h5A5A5A5A;
          @(posedge clk); #1;
          if (j == rv_dly) got = 1'b1;
          else if (used + 1 >= TO) timed = 1'b1;
          used++;
          j++;
        end
        bus.mem_rvalid = 1'b0;
      end
      exp_fault = timed;
      exp_cause = 1'b1;
    end
    exp_done    = 1'b1;
    exp_rd      = rd;
    exp_done_we = !st && !exp_fault && (rd != 5'd0);
    exp_data    = (!st && !exp_fault) ? m_load(f3, addr, rdata) : 32'd0;
    @(posedge clk); #1;
    set_idle();
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; acc_cyc = 0; done_cyc = 0;
    chk_en = 1'b0;
    last_data = 32'd0; last_wdata = 32'd0; last_wstrb = 4'b0000;
    exp_we = 1'b0; exp_done_we = 1'b0; exp_fault = 1'b0; exp_cause = 1'b0;
    exp_addr = 32'd0; exp_wdata = 32'd0; exp_data = 32'd0; exp_wstrb = 4'b0000; exp_rd = 5'd0;
    set_idle();
    bus.req_valid = 1'b0; bus.req_is_store = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.req_rd = 5'd0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
    rst_n = 1'b0;
    #12;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_done_valid", 32'(bus.done_valid), 32'd0);
    chk("rst_done_data", bus.done_data, 32'd0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    run_txn(1'b0, F3_W, 32'h100, 32'd0, 5'd5, 0, 0, 32'hDEADBEEF);
    chk("lw_data_lit", last_data, 32'hDEADBEEF);
    chk("lw_latency", 32'(done_cyc - acc_cyc), 32'd3);
    run_txn(1'b0, F3_B, 32'h103, 32'd0, 5'd7, 0, 0, 32'h80123456);
    chk("lb_data_lit", last_data, 32'hFFFFFF80);
    run_txn(1'b0, F3_BU, 32'h103, 32'd0, 5'd7, 0, 0, 32'h80123456);
    chk("lbu_data_lit", last_data, 32'h00000080);
    run_txn(1'b1, F3_H, 32'h202, 32'h0000ABCD, 5'd3, 0, 0, 32'd0);
    chk("sh_wstrb_lit", 32'(last_wstrb), 32'h0000000C);
    chk("sh_wdata_lit", last_wdata, 32'hABCDABCD);
    chk("sh_latency", 32'(done_cyc - acc_cyc), 32'd2);
    run_txn(1'b0, F3_W, 32'h101, 32'd0, 5'd5, 0, 0, 32'd0);
    chk("mis_latency", 32'(done_cyc - acc_cyc), 32'd1);
    run_txn(1'b0, F3_H, 32'h102, 32'd0, 5'd9, 1, 2, 32'h80017FFF);
    chk("lh_data_lit", last_data, 32'hFFFF8001);
    run_txn(1'b0, F3_HU, 32'h102, 32'd0, 5'd9, 0, 0, 32'h80017FFF);
    run_txn(1'b0, F3_H, 32'h0, 32'd0, 5'd9, 0, 0, 32'h12348765);
    run_txn(1'b0, F3_HU, 32'h101, 32'd0, 5'd9, 0, 0, 32'd0);
    run_txn(1'b1, F3_B, 32'h001, 32'h12345678, 5'd0, 0, 0, 32'd0);
    run_txn(1'b1, F3_W, 32'h010, 32'hCAFEF00D, 5'd0, 5, 0, 32'd0);
    run_txn(1'b1, F3_H, 32'h013, 32'h1111, 5'd0, 0, 0, 32'd0);
    run_txn(1'b0, F3_W, 32'h020, 32'd0, 5'd0, 0, 0, 32'h01020304);
    run_txn(1'b0, 3'b011, 32'h004, 32'd0, 5'd4, 0, 0, 32'h87654321);
    run_txn(1'b0, 3'b111, 32'h006, 32'd0, 5'd4, 0, 0, 32'd0);
    run_txn(1'b0, F3_W, 32'h300, 32'd0, 5'd6, 100, 0, 32'd0);
    chk("to_latency", 32'(done_cyc - acc_cyc), 32'd9);
    run_txn(1'b0, F3_W, 32'h304, 32'd0, 5'd6, 7, 0, 32'h0BADCAFE);
    run_txn(1'b0, F3_W, 32'h308, 32'd0, 5'd6, 0, 10, 32'd0);
    run_txn(1'b1, F3_W, 32'h30C, 32'h55AA55AA, 5'd0, 100, 0, 32'd0);

    // Stray grant/rvalid while idle must not start anything.
    bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
    repeat (3) begin @(posedge clk); #1; end
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;

    // Reset while waiting for read data, then a late rvalid.
    chk_en = 1'b0;
    bus.req_valid = 1'b1; bus.req_is_store = 1'b0; bus.req_funct3 = F3_W;
    bus.req_addr = 32'h400; bus.req_rd = 5'd8;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.mem_gnt = 1'b1;
    chk("rw_mem_req", 32'(bus.mem_req), 32'd1);
    @(posedge clk); #1;
    bus.mem_gnt = 1'b0;
    chk("rw_in_wait", 32'(bus.mem_req), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rw_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rw_mem_req_rst", 32'(bus.mem_req), 32'd0);
    chk("rw_done_valid", 32'(bus.done_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_idle();
    chk_en = 1'b1;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h13572468;
    repeat (3) begin @(posedge clk); #1; end
    bus.mem_rvalid = 1'b0;
    run_txn(1'b0, F3_BU, 32'h402, 32'd0, 5'd8, 0, 0, 32'h00AB0000);
    chk("post_rst_lbu", last_data, 32'h000000AB);
    @(posedge clk); #1;
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
